plate_scanner: RTL
==================

Name: plate_scanner

Overview:
- Multi-plate successor to the single-plate view generator for the oscilloscope Pong XY display.
- Scans NUM_PLATES vertical paddle segments in sequence, clamping each to the playfield.
- Emits (x, y, plate_id) points over a valid/ready stream to the downstream point multiplexer/DAC driver.
- Adds per-plate enable, a step size, a dwell repeat count, optional alternating scan direction and a frame-done pulse.

Parameters:
- NUM_PLATES, 2, number of plates scanned per frame (1..8).
- COORD_W, 8, coordinate width in bits.
- Y_MAX, 220, largest legal y coordinate.
- PLATE_HALFWIDTH, 15, half-length of a plate in y units.
- STEP, 1, y increment between successive distinct points (≥1).
- DWELL, 1, number of consecutive transfers per distinct point (≥1).
- BIDIR, 0, 1 = reverse scan direction every frame; 0 = always ascending.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  start or continue frames.
- plate_en  in  NUM_PLATES  per-plate enable mask.
- y_mid  in  NUM_PLATES*COORD_W  plate centre y; plate i occupies bits [i*COORD_W +: COORD_W].
- x_pos  in  NUM_PLATES*COORD_W  plate x coordinate, same packing as y_mid.
- point_valid  out  1  point on x_out/y_out/plate_id is valid.
- point_ready  in  1  downstream accepts the point.
- x_out  out  COORD_W  point x.
- y_out  out  COORD_W  point y.
- plate_id  out  max(1,$clog2(NUM_PLATES))  index of the plate being drawn.
- frame_done  out  1  one-cycle pulse after the last point of a frame.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE. point_valid, x_out, y_out, plate_id, frame_done and busy are all 0. Direction = ascending. Internal counters = 0.
- States: IDLE, LOAD, EMIT, NEXT.
- IDLE: if enable=1 and plate_en≠0, latch plate_en into mask_r, select the lowest set index, and go to LOAD. If enable=1 and plate_en=0, stay in IDLE with no frame_done.
- LOAD (1 cycle): latch x_pos and y_mid of the selected plate.
  - mid_c = min(y_mid, Y_MAX).
  - y_lo = mid_c ≥ HW ? mid_c−HW : 0.
  - y_hi = mid_c ≤ Y_MAX−HW ? mid_c+HW : Y_MAX.
  - Start y is y_lo when ascending, y_hi when descending. Go to EMIT.
- EMIT: point_valid=1. x_out, y_out and plate_id hold stable until point_valid & point_ready (AXI rule: never drop valid or change data without a transfer). On each transfer:
  - the dwell counter increments;
  - when it reaches DWELL it resets and y advances by ±STEP;
  - ascending: the last point is the largest y_lo+k*STEP ≤ y_hi; descending: the smallest y_hi−k*STEP ≥ y_lo;
  - after the final transfer of the last point, point_valid drops and the block goes to NEXT.
- Arithmetic: y stepping is computed in COORD_W+1 bits, so a step never wraps past 0 or 2^COORD_W−1.
- NEXT (1 cycle): find the next set bit of mask_r above the current index.
  - If one is found, go to LOAD.
  - Otherwise pulse frame_done for 1 cycle, toggle direction if BIDIR=1, and go to IDLE.
- Latency:
  - enable rising in IDLE at edge t → point_valid high after edge t+2.
  - Between plates, point_valid is low for exactly 2 cycles (NEXT, LOAD).
  - Back-to-back frames have a 3-cycle gap (NEXT, IDLE, LOAD).
- Input sampling:
  - enable and plate_en are sampled only in IDLE; deasserting enable mid-frame still completes the frame.
  - y_mid/x_pos changes during EMIT have no effect until the next LOAD.
- Reset mid-EMIT: outputs return to reset values immediately and the partial frame is discarded with no frame_done.
- Single plate (NUM_PLATES=1): plate_id is always 0.

Test Plan:
- NUM_PLATES=1, y_mid=100, x_pos=255, ready=1 → 31 transfers, y=85..115 ascending, x=255, then a frame_done pulse 1 cycle after NEXT.
- Clamp: y_mid=5 → y=0..20 (21 points); y_mid=215 → y=200..220 (21); y_mid=250 → y=205..220 (16).
- Backpressure: hold ready=0 for 3 cycles at y=90 → valid stays high and y_out stays 90, with no skipped or duplicated points.
- NUM_PLATES=2, mid {60,150}, x {0,255}, plate_en=2'b11:
  - plate 0 y=45..75 emitted with plate_id=0;
  - 2 idle-valid cycles follow;
  - plate 1 y=135..165 emitted with plate_id=1;
  - with plate_en=2'b10, only plate 1 is emitted.
- STEP=4, DWELL=2, BIDIR=1, y_mid=100:
  - frame 1: 85,85,89,89,…,113,113 (16 transfers);
  - frame 2: 115,115,111,111,…,87,87.
- Reset asserted mid-EMIT → point_valid=0 and busy=0 at once, no frame_done; after release with enable=1, scanning restarts from y_lo, ascending.

Source files
------------

// File: rtl/plate_scanner_if.sv
// Point stream from the plate scanner to the point multiplexer / DAC driver.
// Valid/ready handshake carrying one (x, y, plate_id) point per transfer.
interface plate_scanner_if #(
  parameter int COORD_W = 8,
  parameter int ID_W    = 1
);
  logic               point_valid;
  logic               point_ready;
  logic [COORD_W-1:0] x_out;
  logic [COORD_W-1:0] y_out;
  logic [ID_W-1:0]    plate_id;

  modport master (output point_valid, x_out, y_out, plate_id, input point_ready);
  modport slave  (input point_valid, x_out, y_out, plate_id, output point_ready);
endinterface

// File: rtl/plate_scanner.sv
// Scans up to NUM_PLATES vertical paddle segments per frame and streams their
// clamped (x, y, plate_id) points, with step, dwell and optional alternating direction.
module plate_scanner #(
  parameter int NUM_PLATES      = 2,
  parameter int COORD_W         = 8,
  parameter int Y_MAX           = 220,
  parameter int PLATE_HALFWIDTH = 15,
  parameter int STEP            = 1,
  parameter int DWELL           = 1,
  parameter int BIDIR           = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_PLATES-1:0]         plate_en,
  input  logic [NUM_PLATES*COORD_W-1:0] y_mid,
  input  logic [NUM_PLATES*COORD_W-1:0] x_pos,
  plate_scanner_if.master               pt,
  output logic                          frame_done,
  output logic                          busy
);
  localparam int ID_W = (NUM_PLATES > 1) ? $clog2(NUM_PLATES) : 1;
  localparam int YW   = COORD_W + 1;
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [YW-1:0]   YMAX_W     = YW'(Y_MAX);
  localparam logic [YW-1:0]   HW_W       = YW'(PLATE_HALFWIDTH);
  localparam logic [YW-1:0]   STEP_W     = YW'(STEP);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_NEXT = 2'd3;

  logic [1:0]            state;
  logic [NUM_PLATES-1:0] mask_r;
  logic [ID_W-1:0]       idx;
  logic                  dir_desc;
  logic [COORD_W-1:0]    x_r;
  logic [COORD_W-1:0]    y_r;
  logic [YW-1:0]         lo_r;
  logic [YW-1:0]         hi_r;
  logic [DW_W-1:0]       dwell_cnt;

  logic [ID_W-1:0]       first_idx;
  logic [ID_W-1:0]       next_idx;
  logic                  next_found;
  logic [COORD_W-1:0]    sel_mid;
  logic [COORD_W-1:0]    sel_x;
  logic [YW-1:0]         mid_c;
  logic [YW-1:0]         ld_lo;
  logic [YW-1:0]         ld_hi;
  logic [YW-1:0]         y_cur;
  logic [YW-1:0]         y_up;
  logic [YW-1:0]         y_dn;
  logic                  last_pt;

  function automatic logic [YW-1:0] clamp_mid(input logic [COORD_W-1:0] m);
    return ({1'b0, m} > YMAX_W) ? YMAX_W : {1'b0, m};
  endfunction

  function automatic logic [YW-1:0] lo_of(input logic [YW-1:0] m);
    return (m >= HW_W) ? (m - HW_W) : '0;
  endfunction

  function automatic logic [YW-1:0] hi_of(input logic [YW-1:0] m);
    return (m <= (YMAX_W - HW_W)) ? (m + HW_W) : YMAX_W;
  endfunction

  always_comb begin
    first_idx  = '0;
    next_idx   = idx;
    next_found = 1'b0;
    sel_mid    = '0;
    sel_x      = '0;
    // Descending loops leave the lowest qualifying index as the winner.
    for (int i = NUM_PLATES - 1; i >= 0; i--) begin
      if (plate_en[i]) first_idx = ID_W'(i);
      if (mask_r[i] && (i > int'(idx))) begin
        next_idx   = ID_W'(i);
        next_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PLATES; i++) begin
      if (int'(idx) == i) begin
        sel_mid = y_mid[i*COORD_W +: COORD_W];
        sel_x   = x_pos[i*COORD_W +: COORD_W];
      end
    end
  end

  assign mid_c = clamp_mid(sel_mid);
  assign ld_lo = lo_of(mid_c);
  assign ld_hi = hi_of(mid_c);

  // One extra bit keeps y +/- STEP from wrapping before the bound test.
  assign y_cur   = {1'b0, y_r};
  assign y_up    = y_cur + STEP_W;
  assign y_dn    = y_cur - STEP_W;
  assign last_pt = dir_desc ? (y_cur < (lo_r + STEP_W)) : (y_up > hi_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mask_r     <= '0;
      idx        <= '0;
      dir_desc   <= 1'b0;
      x_r        <= '0;
      y_r        <= '0;
      lo_r       <= '0;
      hi_r       <= '0;
      dwell_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && (|plate_en)) begin
            mask_r <= plate_en;
            idx    <= first_idx;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          x_r       <= sel_x;
          lo_r      <= ld_lo;
          hi_r      <= ld_hi;
          y_r       <= dir_desc ? ld_hi[COORD_W-1:0] : ld_lo[COORD_W-1:0];
          dwell_cnt <= '0;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          if (pt.point_ready) begin
            if (dwell_cnt == DWELL_LAST) begin
              dwell_cnt <= '0;
              if (last_pt) state <= S_NEXT;
              else y_r <= dir_desc ? y_dn[COORD_W-1:0] : y_up[COORD_W-1:0];
            end else begin
              dwell_cnt <= dwell_cnt + DW_W'(1);
            end
          end
        end
        S_NEXT: begin
          if (next_found) begin
            idx   <= next_idx;
            state <= S_LOAD;
          end else begin
            frame_done <= 1'b1;
            if (BIDIR != 0) dir_desc <= ~dir_desc;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pt.point_valid = (state == S_EMIT);
  assign pt.x_out       = x_r;
  assign pt.y_out       = y_r;
  assign pt.plate_id    = idx;
  assign busy           = (state != S_IDLE);
endmodule
